// File: rtl/encap_packet.sv
`default_nettype none
// ============================================================================
// Module   : encap_packet
// Purpose  : Splits one shadowed DFX word into 19 Aurora 64-bit frames (55b each).
// Revision : 1.0
// ============================================================================
module encap_packet #(
    parameter int DATA_WIDTH        = 1024,
    parameter int ADDR_WIDTH        = 10,
    parameter int DATA_DFX_WIDTH    = DATA_WIDTH + ADDR_WIDTH,
    parameter int AURORA_DATA_WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [DATA_DFX_WIDTH-1:0]    data_dfx_in,
    input  logic                         valid_dfx_in,
    output logic                         ready_dfx_in,
    output logic [AURORA_DATA_WIDTH-1:0] tx_tdata,
    output logic                         tx_tvalid,
    input  logic                         tx_tready,
    output logic                         tx_tlast,
    output logic                         busy,
    output logic                         done_encap_pkt
);

    localparam int         c_payload_bits = 55;
    localparam int         c_num_frames   = (DATA_DFX_WIDTH + c_payload_bits - 1) / c_payload_bits;
    localparam logic [4:0] c_last_idx     = 5'(c_num_frames - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t                         r_state;
    logic [4:0]                     r_frame_cnt;
    logic [DATA_DFX_WIDTH-1:0]      r_shadow;
    logic [AURORA_DATA_WIDTH-1:0]   r_tdata;
    logic                           r_tvalid;
    logic                           r_ready;
    logic                           r_done;

    state_t                         w_state_nxt;
    logic [4:0]                     w_cnt_nxt;
    logic [DATA_DFX_WIDTH-1:0]      w_shadow_nxt;
    logic [AURORA_DATA_WIDTH-1:0]   w_tdata_nxt;
    logic                           w_tvalid_nxt;
    logic                           w_ready_nxt;
    logic                           w_done_nxt;

    logic [DATA_DFX_WIDTH-1:0]      w_src;
    logic [4:0]                     w_idx;
    logic [10:0]                    w_shamt;
    logic [c_payload_bits-1:0]      w_payload;
    logic [AURORA_DATA_WIDTH-1:0]   w_frame;

    // In IDLE the frame about to be loaded is frame 0 of the incoming word,
    // otherwise it is the successor of the frame currently on the bus.
    assign w_src     = (r_state == S_IDLE) ? data_dfx_in : r_shadow;
    assign w_idx     = (r_state == S_IDLE) ? 5'd0 : 5'(r_frame_cnt + 5'd1);
    assign w_shamt   = 11'(w_idx) * 11'(c_payload_bits);
    // The last frame's upper bits fall off the top of the word and read as zero.
    assign w_payload = c_payload_bits'(w_src >> w_shamt);
    assign w_frame   = {w_payload, w_idx, (w_idx == c_last_idx), (w_idx == 5'd0), 2'b00};

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_frame_cnt;
        w_shadow_nxt = r_shadow;
        w_tdata_nxt  = r_tdata;
        w_tvalid_nxt = r_tvalid;
        w_ready_nxt  = r_ready;
        w_done_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready_nxt  = 1'b1;
                w_tvalid_nxt = 1'b0;
                w_tdata_nxt  = '0;
                if (valid_dfx_in && r_ready) begin
                    w_shadow_nxt = data_dfx_in;
                    w_cnt_nxt    = 5'd0;
                    w_tdata_nxt  = w_frame;
                    w_tvalid_nxt = 1'b1;
                    w_ready_nxt  = 1'b0;
                    w_state_nxt  = S_SEND;
                end
            end
            S_SEND: begin
                if (r_tvalid && tx_tready) begin
                    if (r_frame_cnt == c_last_idx) begin
                        w_tvalid_nxt = 1'b0;
                        w_tdata_nxt  = '0;
                        w_done_nxt   = 1'b1;
                        w_ready_nxt  = 1'b1;
                        w_state_nxt  = S_IDLE;
                    end else begin
                        w_cnt_nxt   = 5'(r_frame_cnt + 5'd1);
                        w_tdata_nxt = w_frame;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_frame_cnt <= 5'd0;
            r_shadow    <= '0;
            r_tdata     <= '0;
            r_tvalid    <= 1'b0;
            r_ready     <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_frame_cnt <= w_cnt_nxt;
            r_shadow    <= w_shadow_nxt;
            r_tdata     <= w_tdata_nxt;
            r_tvalid    <= w_tvalid_nxt;
            r_ready     <= w_ready_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign ready_dfx_in   = r_ready;
    assign tx_tdata       = r_tdata;
    assign tx_tvalid      = r_tvalid;
    assign tx_tlast       = r_tvalid && (r_frame_cnt == c_last_idx);
    assign busy           = (r_state == S_SEND);
    assign done_encap_pkt = r_done;

endmodule
`default_nettype wire

// File: tb/tb_encap_packet.sv
`default_nettype none
// ============================================================================
// Module   : tb_encap_packet
// Purpose  : Directed self-checking bench for encap_packet.
// Revision : 1.0
// ============================================================================
module tb_encap_packet;

    localparam int W = 1034;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  data_dfx_in;
    logic          valid_dfx_in;
    logic          ready_dfx_in;
    logic [63:0]   tx_tdata;
    logic          tx_tvalid;
    logic          tx_tready;
    logic          tx_tlast;
    logic          busy;
    logic          done_encap_pkt;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] got [19];
    int          n_got, cyc, stall_bad, tlast_bad, busy_bad;
    logic [15:0] bp_pat = 16'b1011_0010_0110_1001;

    encap_packet dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_dfx_in    (data_dfx_in),
        .valid_dfx_in   (valid_dfx_in),
        .ready_dfx_in   (ready_dfx_in),
        .tx_tdata       (tx_tdata),
        .tx_tvalid      (tx_tvalid),
        .tx_tready      (tx_tready),
        .tx_tlast       (tx_tlast),
        .busy           (busy),
        .done_encap_pkt (done_encap_pkt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected frame k built bit by bit from the word.
    function automatic logic [63:0] exp_frame(input logic [W-1:0] w, input int k);
        logic [63:0] f;
        f = '0;
        for (int j = 0; j < 55; j++)
            if (k * 55 + j < W) f[9 + j] = w[k * 55 + j];
        f[8:4] = k[4:0];
        f[3]   = (k == 18);
        f[2]   = (k == 0);
        return f;
    endfunction

    function automatic int count_bad(input logic [W-1:0] w);
        int c;
        c = 0;
        for (int k = 0; k < 19; k++)
            if (k >= n_got || got[k] !== exp_frame(w, k)) c++;
        return c;
    endfunction

    function automatic logic [W-1:0] reassemble();
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < 19; k++)
            for (int j = 0; j < 55; j++)
                if (k * 55 + j < W) r[k * 55 + j] = got[k][9 + j];
        return r;
    endfunction

    function automatic int first_diff(input logic [W-1:0] a, input logic [W-1:0] b);
        for (int i = 0; i < W; i++)
            if (a[i] !== b[i]) return i;
        return -1;
    endfunction

    task automatic send_word(input logic [W-1:0] w);
        int t;
        t = 0;
        while (ready_dfx_in !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (ready_dfx_in !== 1'b1) begin
            n_err++;
            $display("FAIL send_ready_timeout: ready_dfx_in=%b required 1", ready_dfx_in);
        end
        valid_dfx_in = 1'b1;
        data_dfx_in  = w;
        @(negedge clk);
        valid_dfx_in = 1'b0;
    endtask

    // Drains frames at negedges until 'stop' handshakes; records into got[].
    task automatic collect(input bit bp, input int stop, input bit inj, input logic [W-1:0] inj_w);
        logic        prev_stall;
        logic [63:0] prev_data;
        n_got = 0; cyc = 0; stall_bad = 0; tlast_bad = 0; busy_bad = 0;
        prev_stall = 1'b0; prev_data = '0;
        while (n_got < stop && cyc < 400) begin
            if (prev_stall && (tx_tvalid !== 1'b1 || tx_tdata !== prev_data)) stall_bad++;
            if (tx_tlast !== (tx_tvalid && n_got == 18)) tlast_bad++;
            if (tx_tvalid && !busy) busy_bad++;
            if (inj && cyc == 5) begin
                valid_dfx_in = 1'b1;
                data_dfx_in  = inj_w;
            end
            tx_tready = bp ? bp_pat[cyc % 16] : 1'b1;
            if (tx_tvalid === 1'b1 && tx_tready) begin
                got[n_got] = tx_tdata;
                n_got++;
                prev_stall = 1'b0;
            end else begin
                prev_stall = tx_tvalid;
                prev_data  = tx_tdata;
            end
            cyc++;
            @(negedge clk);
        end
        tx_tready = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({tx_tdata, tx_tvalid, tx_tlast, done_encap_pkt, busy, ready_dfx_in} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: tdata=%h tvalid=%b tlast=%b done=%b busy=%b ready=%b required all 0",
                     tx_tdata, tx_tvalid, tx_tlast, done_encap_pkt, busy, ready_dfx_in);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n_cmp++;
        if (ready_dfx_in !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ready_at_release: ready=%b required 0", ready_dfx_in);
        end
        @(negedge clk);
        n_cmp++;
        if (ready_dfx_in !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready_after_edge: ready=%b required 1", ready_dfx_in);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (ready_dfx_in !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async_assert: ready=%b busy=%b required 0/0", ready_dfx_in, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ready_dfx_in !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready_again: ready=%b required 1", ready_dfx_in);
        end
    endtask

    task automatic test_single();
        logic [W-1:0] w, rec;
        int bad, hdr_bad, d;
        w = {10'h2A5, {512{2'b10}}};
        send_word(w);
        n_cmp++;
        if (tx_tvalid !== 1'b1 || tx_tdata[8:0] !== 9'h004) begin
            n_err++;
            $display("FAIL single_first_latency: tvalid=%b hdr=%h required 1/004", tx_tvalid, tx_tdata[8:0]);
        end
        collect(1'b0, 19, 1'b0, '0);
        n_cmp++;
        if (cyc !== 19 || n_got !== 19) begin
            n_err++;
            $display("FAIL single_consecutive: cycles=%0d frames=%0d required 19/19", cyc, n_got);
        end
        bad = count_bad(w);
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL single_frames: bad frames=%0d required 0", bad);
        end
        n_cmp++;
        if (got[0][8:0] !== 9'h004) begin
            n_err++;
            $display("FAIL single_hdr0: got %h required 004", got[0][8:0]);
        end
        hdr_bad = 0;
        for (int k = 1; k < 18; k++)
            if (got[k][8:0] !== 9'(k << 4)) hdr_bad++;
        n_cmp++;
        if (hdr_bad !== 0) begin
            n_err++;
            $display("FAIL single_hdr_mid: bad headers=%0d required 0", hdr_bad);
        end
        n_cmp++;
        if (got[18][8:0] !== 9'h128 || got[18][63:53] !== 11'h0) begin
            n_err++;
            $display("FAIL single_hdr18: hdr=%h top=%h required 128/000", got[18][8:0], got[18][63:53]);
        end
        n_cmp++;
        if (tlast_bad !== 0 || busy_bad !== 0) begin
            n_err++;
            $display("FAIL single_tlast_busy: tlast errs=%0d busy errs=%0d required 0/0", tlast_bad, busy_bad);
        end
        rec = reassemble();
        d = first_diff(rec, w);
        n_cmp++;
        if (d >= 0) begin
            n_err++;
            $display("FAIL single_reassemble: bit %0d got %b required %b", d, rec[d], w[d]);
        end
        n_cmp++;
        if (done_encap_pkt !== 1'b1 || ready_dfx_in !== 1'b1 || tx_tvalid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_done: done=%b ready=%b tvalid=%b busy=%b required 1/1/0/0",
                     done_encap_pkt, ready_dfx_in, tx_tvalid, busy);
        end
        @(negedge clk);
        n_cmp++;
        if (done_encap_pkt !== 1'b0) begin
            n_err++;
            $display("FAIL single_done_width: done=%b required 0", done_encap_pkt);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] w;
        int bad;
        w = {10'h3C3, {128{8'hA5}}};
        send_word(w);
        collect(1'b1, 19, 1'b0, '0);
        n_cmp++;
        if (n_got !== 19 || cyc <= 19) begin
            n_err++;
            $display("FAIL bp_count: frames=%0d cycles=%0d required 19/>19", n_got, cyc);
        end
        n_cmp++;
        if (stall_bad !== 0 || tlast_bad !== 0) begin
            n_err++;
            $display("FAIL bp_stall_stable: stall errs=%0d tlast errs=%0d required 0/0", stall_bad, tlast_bad);
        end
        bad = count_bad(w);
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL bp_frames: bad frames=%0d required 0", bad);
        end
        n_cmp++;
        if (done_encap_pkt !== 1'b1) begin
            n_err++;
            $display("FAIL bp_done: done=%b required 1", done_encap_pkt);
        end
        @(negedge clk);
    endtask

    task automatic test_busy_ignore();
        logic [W-1:0] w3, w4;
        int bad;
        w3 = {10'h0F0, {32{32'hDEADBEEF}}};
        w4 = {10'h10F, {16{64'h0123456789ABCDEF}}};
        send_word(w3);
        collect(1'b0, 19, 1'b1, w4);
        bad = count_bad(w3);
        n_cmp++;
        if (n_got !== 19 || bad !== 0) begin
            n_err++;
            $display("FAIL busy_inflight: frames=%0d bad=%0d required 19/0", n_got, bad);
        end
        n_cmp++;
        if (tx_tvalid !== 1'b0 || ready_dfx_in !== 1'b1 || done_encap_pkt !== 1'b1) begin
            n_err++;
            $display("FAIL busy_not_early: tvalid=%b ready=%b done=%b required 0/1/1",
                     tx_tvalid, ready_dfx_in, done_encap_pkt);
        end
        @(negedge clk);
        valid_dfx_in = 1'b0;
        n_cmp++;
        if (tx_tvalid !== 1'b1 || tx_tdata[8:0] !== 9'h004 || ready_dfx_in !== 1'b0) begin
            n_err++;
            $display("FAIL busy_second_start: tvalid=%b hdr=%h ready=%b required 1/004/0",
                     tx_tvalid, tx_tdata[8:0], ready_dfx_in);
        end
        collect(1'b0, 19, 1'b0, '0);
        bad = count_bad(w4);
        n_cmp++;
        if (n_got !== 19 || bad !== 0) begin
            n_err++;
            $display("FAIL busy_second_frames: frames=%0d bad=%0d required 19/0", n_got, bad);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] w5, w6;
        int bad, dones;
        w5 = {10'h3FF, {1024{1'b1}}};
        w6 = {10'h001, {256{4'h6}}};
        send_word(w5);
        collect(1'b0, 7, 1'b0, '0);
        n_cmp++;
        if (tx_tvalid !== 1'b1 || tx_tdata[8:4] !== 5'd7) begin
            n_err++;
            $display("FAIL rmid_at_frame7: tvalid=%b idx=%0d required 1/7", tx_tvalid, tx_tdata[8:4]);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (tx_tvalid !== 1'b0 || done_encap_pkt !== 1'b0 || busy !== 1'b0 || tx_tdata !== 64'h0 || tx_tlast !== 1'b0) begin
            n_err++;
            $display("FAIL rmid_async_drop: tvalid=%b done=%b busy=%b tdata=%h tlast=%b required 0",
                     tx_tvalid, done_encap_pkt, busy, tx_tdata, tx_tlast);
        end
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            if (done_encap_pkt !== 1'b0) dones++;
        end
        n_cmp++;
        if (dones !== 0) begin
            n_err++;
            $display("FAIL rmid_no_done: done cycles=%0d required 0", dones);
        end
        send_word(w6);
        n_cmp++;
        if (tx_tvalid !== 1'b1 || tx_tdata[8:0] !== 9'h004) begin
            n_err++;
            $display("FAIL rmid_restart_hdr: tvalid=%b hdr=%h required 1/004", tx_tvalid, tx_tdata[8:0]);
        end
        collect(1'b0, 19, 1'b0, '0);
        bad = count_bad(w6);
        n_cmp++;
        if (n_got !== 19 || bad !== 0) begin
            n_err++;
            $display("FAIL rmid_new_frames: frames=%0d bad=%0d required 19/0", n_got, bad);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] words [3];
        logic [63:0]  pk [3][19];
        int starts [3];
        int p, fc, acc, dones, bad;
        bit pend;
        words[0] = {10'h2AA, {64{16'h1234}}};
        words[1] = {10'h155, {64{16'hFEDC}}};
        words[2] = {10'h0C3, {1023{1'b0}}, 1'b1};
        starts = '{-1, -1, -1};
        p = 0; fc = 0; acc = 0; dones = 0; pend = 1'b0;
        tx_tready    = 1'b1;
        valid_dfx_in = 1'b1;
        data_dfx_in  = words[0];
        for (int c = 0; c < 90; c++) begin
            if (done_encap_pkt === 1'b1) dones++;
            if (tx_tvalid === 1'b1 && p < 3) begin
                if (fc == 0) starts[p] = c;
                pk[p][fc] = tx_tdata;
                fc++;
                if (fc == 19) begin
                    fc = 0;
                    p++;
                end
            end
            if (pend) begin
                pend = 1'b0;
                if (acc < 3) data_dfx_in = words[acc];
                else valid_dfx_in = 1'b0;
            end
            if (ready_dfx_in === 1'b1 && valid_dfx_in) begin
                acc++;
                pend = 1'b1;
            end
            @(negedge clk);
        end
        valid_dfx_in = 1'b0;
        n_cmp++;
        if (acc !== 3 || p !== 3) begin
            n_err++;
            $display("FAIL b2b_counts: accepted=%0d packets=%0d required 3/3", acc, p);
        end
        n_cmp++;
        if (starts[1] - starts[0] !== 20 || starts[2] - starts[1] !== 20) begin
            n_err++;
            $display("FAIL b2b_period: starts=%0d,%0d,%0d required spacing 20", starts[0], starts[1], starts[2]);
        end
        n_cmp++;
        if (dones !== 3) begin
            n_err++;
            $display("FAIL b2b_done_pulses: done cycles=%0d required 3", dones);
        end
        for (int i = 0; i < 3; i++) begin
            got   = pk[i];
            n_got = 19;
            bad   = count_bad(words[i]);
            n_cmp++;
            if (bad !== 0) begin
                n_err++;
                $display("FAIL b2b_payload%0d: bad frames=%0d required 0", i, bad);
            end
        end
    endtask

    initial begin
        rst_n        = 1'b1;
        valid_dfx_in = 1'b0;
        data_dfx_in  = '0;
        tx_tready    = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/encap_packet.md
# encap_packet

Transmit-side packetizer for the output port Aurora link. It accepts one DFX word per packet, 1034 bits of data plus address, and holds it in a shadow register. It then streams the word as 19 Aurora 64-bit frames on a valid/ready interface toward the Aurora TX user port. The frame layout is exactly the one the receive-side decapsulator unpacks: 55 payload bits per frame in [63:9], with the 44-bit remainder in the last frame.

## Interface
- DATA_WIDTH, 1024, payload data width.
- ADDR_WIDTH, 10, address width.
- DATA_DFX_WIDTH, DATA_WIDTH + ADDR_WIDTH, packed DFX word width. Only the default of 1034 is verified.
- AURORA_DATA_WIDTH, 64, Aurora frame width.

- clk  input  1  single clock, all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- data_dfx_in  input  DATA_DFX_WIDTH  DFX word to send; sampled only on an input handshake.
- valid_dfx_in  input  1  data_dfx_in is valid.
- ready_dfx_in  output  1  registered; block can accept a word.
- tx_tdata  output  AURORA_DATA_WIDTH  registered frame.
- tx_tvalid  output  1  tx_tdata is valid.
- tx_tready  input  1  Aurora TX accepts the frame.
- tx_tlast  output  1  current frame is frame 18.
- busy  output  1  a packet is in flight (state SEND).
- done_encap_pkt  output  1  one-cycle pulse after the last frame is accepted.

## Operation
- Constants:
  - NUM_FRAMES = ceil(DATA_DFX_WIDTH/55) = 19.
  - LAST_BITS = DATA_DFX_WIDTH − 55·18 = 44.
  - frame_cnt is 5 bits.
- States: IDLE and SEND.
- IDLE:
  - ready_dfx_in = 1.
  - tx_tvalid = 0.
  - tx_tdata = 0.
  - On valid_dfx_in && ready_dfx_in: latch data_dfx_in into the shadow register, set frame_cnt = 0, load frame 0 into tx_tdata, set tx_tvalid = 1 and ready_dfx_in = 0, go to SEND.
- SEND:
  - tx_tdata, tx_tvalid and tx_tlast hold while tx_tready = 0.
  - On tx_tvalid && tx_tready with frame_cnt < 18: increment frame_cnt and load the next frame.
  - On the handshake with frame_cnt = 18: set tx_tvalid = 0, tx_tdata = 0, pulse done_encap_pkt, set ready_dfx_in = 1, go to IDLE.
- Frame k layout, for k = 0..17:
  - [63:9] = shadow[k·55 +: 55].
  - [8:4] = k.
  - [3] = 0 (last flag).
  - [2] = 1 if k = 0, else 0 (first flag).
  - [1:0] = 2'b00.
- Frame 18 layout:
  - [63:53] = 0.
  - [52:9] = shadow[1033:990].
  - [8:4] = 18.
  - [3] = 1.
  - [2] = 0.
  - [1:0] = 0.
- tx_tlast = tx_tvalid && (frame_cnt == 18).
- busy = (state == SEND).
- valid_dfx_in and data_dfx_in are ignored outside IDLE. Changing data_dfx_in mid-packet does not affect the frames being sent.
- Reset, including in the middle of a packet:
  - state = IDLE, frame_cnt = 0, shadow = 0.
  - tx_tdata = 0, tx_tvalid = 0, tx_tlast = 0.
  - done_encap_pkt = 0, busy = 0, ready_dfx_in = 0.
  - ready_dfx_in rises on the first clk edge after rst_n deasserts.
  - A partially sent packet is dropped; the next packet starts at frame 0.

## Timing
- Input handshake at edge N: frame 0 appears on tx_tdata with tx_tvalid = 1 in the cycle after edge N.
- With tx_tready held at 1, frames 0..18 occupy 19 consecutive cycles.
- done_encap_pkt and ready_dfx_in = 1 appear in the cycle after the frame-18 handshake.
- Minimum packet period is 20 cycles; back-to-back packets have one idle cycle between frame 18 and the next frame 0.
- Each stall cycle (tx_tready = 0) adds exactly one cycle. No frame is dropped or duplicated.
- done_encap_pkt is exactly one cycle wide per packet.

## Test plan
- Reset:
  - Stimulus: assert rst_n = 0 asynchronously between edges, then release.
  - Required: all outputs are 0 immediately on assertion; ready_dfx_in = 1 one edge after release.
- Single packet:
  - Stimulus: data_dfx_in = {10'h2A5, 1024 bits with bit i = i[0]}, tx_tready = 1.
  - Required: 19 consecutive frames.
  - Required: frame 0 has tx_tdata[8:0] = 9'h004.
  - Required: frames 1..17 have [8:0] = k<<4.
  - Required: frame 18 has [8:0] = 9'h128 and [63:53] = 0, with tx_tlast on that frame only.
  - Required: concatenating the [63:9] fields (44 bits from frame 18) reproduces the input word.
  - Required: done_encap_pkt pulses one cycle after frame 18.
- Backpressure:
  - Stimulus: tx_tready follows a pseudo-random pattern of about 50% duty.
  - Required: tx_tdata is stable on every stalled cycle.
  - Required: exactly 19 handshakes occur, with the frame sequence identical to the single-packet case.
- Input ignored while busy:
  - Stimulus: while in SEND, pulse valid_dfx_in with a different word and change data_dfx_in.
  - Required: the in-flight frames are unchanged.
  - Required: the second word is accepted only after ready_dfx_in returns to 1.
- Reset mid-packet:
  - Stimulus: assert rst_n during frame 7, then release and send a new word.
  - Required: tx_tvalid drops to 0 with no done_encap_pkt pulse.
  - Required: after release, the new word starts at frame 0 with a header of 9'h004.
- Back-to-back:
  - Stimulus: valid_dfx_in held at 1 for three words, tx_tready = 1.
  - Required: packet starts 20 cycles apart.
  - Required: three done_encap_pkt pulses.
  - Required: each packet's payload matches its own input word.
